spi_slave_responder: RTL



---
 rtl/spi_slave_responder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave_responder.sv
// SPI peripheral-side responder: oversamples SCLK/CS_n/MOSI in the i_Clk domain,
// receives bytes MSb first on MOSI and returns the holding-register byte on MISO.
module spi_slave_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [1:0] spimode,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_CS_n,
  input  logic       i_SPI_MOSI,
  output logic       o_SPI_MISO,
  output logic       o_SPI_MISO_En,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, vld_sync_q;
  logic                   sclk_prev_q;
  logic                   armed_q, armed_d;
  logic [0:0]             state_q, state_d;
  logic                   cpol_q, cpol_d, cpha_q, cpha_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             rx_shift_q, rx_shift_d;
  logic [7:0]             rx_byte_q, rx_byte_d;
  logic                   rx_dv_q, rx_dv_d;
  logic [7:0]             tx_shift_q, tx_shift_d;
  logic                   miso_q, miso_d, miso_en_q, miso_en_d;
  logic [7:0]             hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;

  logic sclk_s, cs_s, mosi_s;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise, active_ok, load;
  logic [7:0] load_byte;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign lead_edge   = (sclk_prev_q == cpol_q) && (sclk_s != cpol_q);
  assign trail_edge  = (sclk_prev_q != cpol_q) && (sclk_s == cpol_q);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

  // armed_q means CS_n was genuinely seen high, so a falling edge after reset
  // cannot be faked by the synchronizer draining from its reset value.
  assign cs_fall   = (state_q == ST_IDLE) && armed_q && !cs_s;
  assign cs_rise   = (state_q == ST_ACTIVE) && cs_s;
  assign active_ok = (state_q == ST_ACTIVE) && !cs_s;

  assign load      = (cs_fall && !spimode[0]) ||
                     (active_ok && shift_edge && (bit_cnt_q == 3'd7));
  assign load_byte = hold_full_q ? hold_q : 8'h00;

  always_comb begin
    armed_d     = vld_sync_q[SYNC_STAGES-1] & cs_s;
    state_d     = state_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_byte_d   = rx_byte_q;
    rx_dv_d     = 1'b0;
    tx_shift_d  = tx_shift_q;
    miso_d      = miso_q;
    miso_en_d   = miso_en_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    if (cs_fall) begin
      state_d   = ST_ACTIVE;
      cpol_d    = spimode[1];
      cpha_d    = spimode[0];
      bit_cnt_d = 3'd7;
      miso_en_d = 1'b1;
    end
    if (cs_rise) begin
      state_d   = ST_IDLE;
      miso_en_d = 1'b0;
    end

    if (active_ok && sample_edge) begin
      rx_shift_d[bit_cnt_q] = mosi_s;
      bit_cnt_d             = bit_cnt_q - 3'd1;
      if (bit_cnt_q == 3'd0) begin
        rx_byte_d = rx_shift_d;
        rx_dv_d   = 1'b1;
      end
    end

    if (load) begin
      miso_d      = load_byte[7];
      tx_shift_d  = {load_byte[6:0], 1'b0};
      hold_full_d = 1'b0;
    end else if (active_ok && shift_edge) begin
      miso_d     = tx_shift_q[7];
      tx_shift_d = {tx_shift_q[6:0], 1'b0};
    end

    // A write coinciding with a load refills the register the load just emptied.
    if (i_TX_DV && (!hold_full_q || load)) begin
      hold_d      = i_TX_Byte;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sclk_sync_q <= {SYNC_STAGES{spimode[1]}};
      cs_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= '0;
      vld_sync_q  <= '0;
      sclk_prev_q <= spimode[1];
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd7;
      rx_byte_q   <= 8'h00;
      rx_dv_q     <= 1'b0;
      miso_q      <= 1'b0;
      miso_en_q   <= 1'b0;
      hold_full_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_SPI_Clk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_SPI_CS_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_SPI_MOSI};
      vld_sync_q  <= {vld_sync_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_s;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_byte_q   <= rx_byte_d;
      rx_dv_q     <= rx_dv_d;
      miso_q      <= miso_d;
      miso_en_q   <= miso_en_d;
      hold_full_q <= hold_full_d;
    end
  end

  always_ff @(posedge i_Clk) begin
    cpol_q     <= cpol_d;
    cpha_q     <= cpha_d;
    rx_shift_q <= rx_shift_d;
    tx_shift_q <= tx_shift_d;
    hold_q     <= hold_d;
  end

  assign o_SPI_MISO    = miso_q;
  assign o_SPI_MISO_En = miso_en_q;
  assign o_TX_Ready    = !hold_full_q;
  assign o_RX_DV       = rx_dv_q;
  assign o_RX_Byte     = rx_byte_q;

endmodule
